resp_misr_chk: RTL
==================

RESP_MISR_CHK -- requirements
Module: resp_misr_chk

Interface
REQ-001 SHALL have parameter WIDTH, default 39, response word width (number of s9234 primary outputs).
REQ-002 SHALL have parameter NCYC, default 100, number of response words compacted per run.
REQ-003 SHALL have parameter NSKIP, default 2, number of leading cycles discarded after start.
REQ-004 SHALL have port CK, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port RST, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1, pulse that begins a run, accepted only in IDLE.
REQ-007 SHALL have port resp, input, WIDTH, DUT output word, sampled every cycle while resp_valid=1.
REQ-008 SHALL have port resp_valid, input, 1, resp is meaningful this cycle.
REQ-009 SHALL have port golden, input, WIDTH, expected final signature, held stable through CHECK.
REQ-010 SHALL have port busy, output, 1, high in SKIP and COMPACT.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when the verdict becomes valid.
REQ-012 SHALL have port pass, output, 1, verdict, valid from done until next start or RST.
REQ-013 SHALL have port signature, output, WIDTH, current MISR contents.
REQ-014 SHALL have port count, output, 8, response words compacted so far.

Function
REQ-015 SHALL implement FSM IDLE -> SKIP -> COMPACT -> CHECK -> IDLE.
REQ-016 SHALL, in IDLE on start=1, clear signature and count to 0 and enter SKIP (SKIP is bypassed to COMPACT when NSKIP=0).
REQ-017 SHALL, in SKIP, count NSKIP resp_valid cycles without compacting, then enter COMPACT.
REQ-018 SHALL, in COMPACT, on each resp_valid=1 cycle, update signature as a Galois MISR: nxt[0]=sig[WIDTH-1]^resp[0]; nxt[i]=sig[i-1]^resp[i]^(TAP[i]&sig[WIDTH-1]) for i>0.
REQ-019 SHALL hold signature and count unchanged on resp_valid=0 cycles (stall), in SKIP and COMPACT alike.
REQ-020 SHALL increment count per compacted word and leave COMPACT for CHECK on the cycle the NCYC-th word is compacted.
REQ-021 SHALL, in CHECK, register pass=(signature==golden), pulse done for exactly one cycle, and return to IDLE (total latency: last word edge +1 cycle).
REQ-022 SHALL ignore start while not in IDLE.
REQ-023 SHALL accept a start arriving in the same cycle done is high only on the following cycle (in IDLE).

Reset
REQ-024 SHALL, when RST=1 at a rising edge, force IDLE, signature=0, count=0, busy=0, done=0, pass=0, overriding start and any run in progress.

Configuration
REQ-025 SHALL, with macro RESP_MISR_MASK_EN defined, add input xmask (WIDTH), whose bits set to 1 force the corresponding resp bits to 0 before compaction.
REQ-026 SHALL, without RESP_MISR_MASK_EN, have no xmask port and compact resp unmasked.

Structure
REQ-027 SHALL place the state enum, default TAP vector (x^39+x^35+1, i.e. TAP[35]=1 only) and WIDTH/NCYC defaults in package resp_misr_pkg.
REQ-028 SHALL implement the one-step MISR update as sub-module misr_step (combinational: sig, data -> nxt), instantiated once.

Verification
REQ-029 SHALL cover: RST, start, resp=0 all cycles, golden=0 -> done after NSKIP+NCYC+1 valid-cycle edges, pass=1, signature=0.
REQ-030 SHALL cover: resp=0 except resp=39'h1 on the final (100th) compacted word -> signature=39'h1; golden=39'h1 -> pass=1, golden=0 -> pass=0.
REQ-031 SHALL cover: resp=39'h1 on first compacted word only, then zeros -> signature equals a software model of 99 MISR shifts; mismatching golden -> pass=0.
REQ-032 SHALL cover: resp_valid deasserted for 5 cycles mid-COMPACT -> count and signature frozen; final signature identical to the unstalled run.
REQ-033 SHALL cover: RST asserted at count=50 -> next cycle IDLE, signature=0, count=0, busy=0; a fresh start completes normally.
REQ-034 SHALL cover (RESP_MISR_MASK_EN): xmask=39'h1, resp=39'h1 every word -> signature=0, pass=1 against golden=0.

Source files
------------

// File: rtl/resp_misr_pkg.sv
// Shared types and defaults for the response MISR checker.
// RESP_MISR_MASK_EN (see resp_misr_chk) adds a per-bit response mask.
package resp_misr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StCompact,
        StCheck
    } state_e;

    localparam int unsigned DefWidth = 39;
    localparam int unsigned DefNcyc  = 100;
    localparam int unsigned DefNskip = 2;

    // x^39 + x^35 + 1: only the x^35 feedback tap is explicit.
    localparam logic [38:0] DefTap = 39'h08_0000_0000;

endpackage

// File: rtl/misr_step.sv
// One combinational Galois MISR step: folds one data word into the signature.
module misr_step #(
    parameter int unsigned      WIDTH = 39,
    parameter logic [WIDTH-1:0] TAP   = '0
) (
    input  logic [WIDTH-1:0] sig_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] nxt_o
);

    logic fb;

    assign fb = sig_i[WIDTH-1];

    // TAP[0] is ignored: bit 0 always takes the feedback bit directly.
    always_comb begin
        nxt_o    = '0;
        nxt_o[0] = fb ^ data_i[0];
        for (int i = 1; i < WIDTH; i++) begin
            nxt_o[i] = sig_i[i-1] ^ data_i[i] ^ (TAP[i] & fb);
        end
    end

endmodule

// File: rtl/resp_misr_chk.sv
// Compacts NCYC response words into a MISR signature and compares it to golden.
// Define RESP_MISR_MASK_EN to add the xmask input that zeroes masked resp bits.
module resp_misr_chk
    import resp_misr_pkg::*;
#(
    parameter int unsigned      WIDTH = DefWidth,
    parameter int unsigned      NCYC  = DefNcyc,
    parameter int unsigned      NSKIP = DefNskip,
    parameter logic [WIDTH-1:0] TAP   = WIDTH'(DefTap)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] resp,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] golden,
`ifdef RESP_MISR_MASK_EN
    input  logic [WIDTH-1:0] xmask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [7:0]       count
);

    localparam logic [7:0] LastWord = 8'(NCYC - 1);
    localparam logic [7:0] LastSkip = 8'(NSKIP - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       skip_q, skip_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] resp_eff;
    logic [WIDTH-1:0] sig_step;

`ifdef RESP_MISR_MASK_EN
    assign resp_eff = resp & ~xmask;
`else
    assign resp_eff = resp;
`endif

    misr_step #(
        .WIDTH (WIDTH),
        .TAP   (TAP)
    ) u_misr_step (
        .sig_i  (sig_q),
        .data_i (resp_eff),
        .nxt_o  (sig_step)
    );

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        skip_d  = skip_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sig_d   = '0;
                    count_d = '0;
                    skip_d  = '0;
                    pass_d  = 1'b0;
                    state_d = (NSKIP == 0) ? StCompact : StSkip;
                end
            end
            StSkip: begin
                if (resp_valid) begin
                    if (skip_q == LastSkip) begin
                        state_d = StCompact;
                    end else begin
                        skip_d = skip_q + 8'd1;
                    end
                end
            end
            StCompact: begin
                if (resp_valid) begin
                    sig_d   = sig_step;
                    count_d = count_q + 8'd1;
                    if (count_q == LastWord) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                pass_d  = (sig_q == golden);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= StIdle;
            sig_q   <= '0;
            count_q <= '0;
            skip_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            skip_q  <= skip_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == StSkip) || (state_q == StCompact);
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign count     = count_q;

endmodule
